// File: rtl/fpu_wb_queue.sv
// rtl/fpu_wb_queue.sv - FPU result queue feeding the CDB, with issue credit and flush handling
module fpu_wb_queue #(
    parameter int DEPTH     = 4,
    parameter int ROB_IDX_W = 3,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fpu_start,
    input  logic                 fpu_o_valid,
    input  logic [XLEN-1:0]      fpu_out,
    input  logic [ROB_IDX_W-1:0] fpu_rob_idx,
    input  logic                 flush,
    output logic                 fpu_issue_ok,
    output logic                 cdb_valid,
    output logic [XLEN-1:0]      cdb_data,
    output logic [ROB_IDX_W-1:0] cdb_rob_idx,
    input  logic                 cdb_ready,
    output logic                 overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);
    localparam logic [OCC_W:0]   DEPTH_EXT = (OCC_W + 1)'(DEPTH);

    logic [XLEN-1:0]      data_q [DEPTH];
    logic [ROB_IDX_W-1:0] idx_q  [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [OCC_W-1:0]     occ;
    logic                 armed;
    logic                 drop_next;

    logic                 push;
    logic                 pop;
    logic                 push_ok;
    logic [OCC_W:0]       credit_sum;

    // The result itself carries everything the queue needs; start only gates issue upstream.
    logic unused_fpu_start;
    assign unused_fpu_start = fpu_start;

    assign cdb_valid   = (occ != '0);
    assign cdb_data    = data_q[rd_ptr];
    assign cdb_rob_idx = idx_q[rd_ptr];

    assign push    = armed & fpu_o_valid & ~flush & ~drop_next;
    assign pop     = cdb_valid & cdb_ready & ~flush;
    assign push_ok = push & ((occ < OCC_FULL) | pop);

    // Conservative credit: a same-cycle pop is not counted, so no cdb_ready path exists.
    assign credit_sum   = {1'b0, occ} + {{OCC_W{1'b0}}, fpu_o_valid};
    assign fpu_issue_ok = armed & ~flush & (credit_sum < DEPTH_EXT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed        <= 1'b0;
            drop_next    <= 1'b0;
            overflow_err <= 1'b0;
            occ          <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                idx_q[i]  <= '0;
            end
        end else begin
            armed     <= 1'b1;
            drop_next <= flush;
            if (push & ~push_ok) begin
                overflow_err <= 1'b1;
            end
            if (push_ok) begin
                data_q[wr_ptr] <= fpu_out;
                idx_q[wr_ptr]  <= fpu_rob_idx;
            end
            if (flush) begin
                occ    <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push_ok, pop})
                    2'b10:   occ <= occ + 1'b1;
                    2'b01:   occ <= occ - 1'b1;
                    default: occ <= occ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fpu_wb_queue.sv
// tb/tb_fpu_wb_queue.sv - directed table and sequence checks for fpu_wb_queue
module tb_fpu_wb_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        fpu_start;
    logic        fpu_o_valid;
    logic [31:0] fpu_out;
    logic [2:0]  fpu_rob_idx;
    logic        flush;
    logic        fpu_issue_ok;
    logic        cdb_valid;
    logic [31:0] cdb_data;
    logic [2:0]  cdb_rob_idx;
    logic        cdb_ready;
    logic        overflow_err;

    int errors = 0;
    int checks = 0;

    fpu_wb_queue #(.DEPTH(4), .ROB_IDX_W(3), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .fpu_start    (fpu_start),
        .fpu_o_valid  (fpu_o_valid),
        .fpu_out      (fpu_out),
        .fpu_rob_idx  (fpu_rob_idx),
        .flush        (flush),
        .fpu_issue_ok (fpu_issue_ok),
        .cdb_valid    (cdb_valid),
        .cdb_data     (cdb_data),
        .cdb_rob_idx  (cdb_rob_idx),
        .cdb_ready    (cdb_ready),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        v;
        logic [31:0] d;
        logic [2:0]  i;
        logic        fl;
        logic        rdy;
        logic        ok;
        logic        cv;
        logic [31:0] cd;
        logic [2:0]  ci;
        logic        ov;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(logic st, logic v, logic [31:0] d, logic [2:0] i, logic fl,
                                logic rdy, logic ok, logic cv, logic [31:0] cd, logic [2:0] ci);
        vec_t r;
        r.st = st; r.v = v; r.d = d; r.i = i; r.fl = fl; r.rdy = rdy;
        r.ok = ok; r.cv = cv; r.cd = cd; r.ci = ci; r.ov = 1'b0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic v, input logic [31:0] d, input logic [2:0] i,
                         input logic fl, input logic rdy);
        fpu_start   = st;
        fpu_o_valid = v;
        fpu_out     = d;
        fpu_rob_idx = i;
        flush       = fl;
        cdb_ready   = rdy;
    endtask

    logic [31:0] model_d [$];
    logic [2:0]  model_i [$];

    initial begin
        // single op, backpressure to full, drain, flush
        tbl[0]  = mk(0, 0, 32'h0,        0, 0, 1, 1, 0, 32'h0,        0);
        tbl[1]  = mk(1, 0, 32'h0,        0, 0, 1, 1, 0, 32'h0,        0);
        tbl[2]  = mk(0, 1, 32'h40400000, 5, 0, 1, 1, 0, 32'h0,        0);
        tbl[3]  = mk(0, 0, 32'h0,        0, 0, 1, 1, 1, 32'h40400000, 5);
        tbl[4]  = mk(0, 0, 32'h0,        0, 0, 1, 1, 0, 32'h0,        0);
        tbl[5]  = mk(1, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0,        0);
        tbl[6]  = mk(1, 1, 32'hA0,       0, 0, 0, 1, 0, 32'h0,        0);
        tbl[7]  = mk(1, 1, 32'hA1,       1, 0, 0, 1, 1, 32'hA0,       0);
        tbl[8]  = mk(1, 1, 32'hA2,       2, 0, 0, 1, 1, 32'hA0,       0);
        tbl[9]  = mk(0, 1, 32'hA3,       3, 0, 0, 0, 1, 32'hA0,       0);
        tbl[10] = mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'hA0,       0);
        tbl[11] = mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'hA0,       0);
        tbl[12] = mk(0, 0, 32'h0,        0, 0, 1, 0, 1, 32'hA0,       0);
        tbl[13] = mk(0, 0, 32'h0,        0, 0, 1, 1, 1, 32'hA1,       1);
        tbl[14] = mk(0, 0, 32'h0,        0, 0, 1, 1, 1, 32'hA2,       2);
        tbl[15] = mk(0, 0, 32'h0,        0, 0, 1, 1, 1, 32'hA3,       3);
        tbl[16] = mk(0, 0, 32'h0,        0, 0, 1, 1, 0, 32'h0,        0);
        tbl[17] = mk(1, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0,        0);
        tbl[18] = mk(1, 1, 32'hB0,       6, 0, 0, 1, 0, 32'h0,        0);
        tbl[19] = mk(0, 1, 32'hB1,       7, 0, 0, 1, 1, 32'hB0,       6);
        tbl[20] = mk(1, 1, 32'hB2,       1, 1, 1, 0, 1, 32'hB0,       6);
        tbl[21] = mk(1, 1, 32'hB3,       2, 0, 1, 1, 0, 32'h0,        0);
        tbl[22] = mk(0, 1, 32'hB4,       3, 0, 1, 1, 0, 32'h0,        0);
        tbl[23] = mk(0, 0, 32'h0,        0, 0, 1, 1, 1, 32'hB4,       3);
        tbl[24] = mk(0, 0, 32'h0,        0, 0, 1, 1, 0, 32'h0,        0);

        // reset and arming, with garbage on the unreset FPU valid
        rst = 1'b0;
        drive(0, 1, 'x, 'x, 0, 1);
        repeat (2) @(negedge clk);
        #1;
        chk("reset cdb_valid", {31'b0, cdb_valid}, 32'd0);
        chk("reset issue_ok", {31'b0, fpu_issue_ok}, 32'd0);
        chk("reset overflow", {31'b0, overflow_err}, 32'd0);
        chk("reset cdb_data", cdb_data, 32'd0);
        chk("reset cdb_idx", {29'b0, cdb_rob_idx}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("unarmed issue_ok", {31'b0, fpu_issue_ok}, 32'd0);
        chk("unarmed cdb_valid", {31'b0, cdb_valid}, 32'd0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 1);
        #1;
        chk("armed issue_ok", {31'b0, fpu_issue_ok}, 32'd1);
        chk("armed cdb_valid", {31'b0, cdb_valid}, 32'd0);

        for (int r = 0; r < 25; r++) begin
            @(negedge clk);
            drive(tbl[r].st, tbl[r].v, tbl[r].d, tbl[r].i, tbl[r].fl, tbl[r].rdy);
            #1;
            chk($sformatf("row%0d issue_ok", r), {31'b0, fpu_issue_ok}, {31'b0, tbl[r].ok});
            chk($sformatf("row%0d cdb_valid", r), {31'b0, cdb_valid}, {31'b0, tbl[r].cv});
            chk($sformatf("row%0d overflow", r), {31'b0, overflow_err}, {31'b0, tbl[r].ov});
            if (tbl[r].cv) begin
                chk($sformatf("row%0d cdb_data", r), cdb_data, tbl[r].cd);
                chk($sformatf("row%0d cdb_idx", r), {29'b0, cdb_rob_idx}, {29'b0, tbl[r].ci});
            end
        end

        // streaming with cdb_ready toggling; bench acts as issue stage honouring credit
        begin
            int issued = 0;
            int got = 0;
            logic pend = 1'b0;
            logic [31:0] pd = 32'h0;
            logic [2:0]  pi = 3'd0;
            for (int c = 0; c < 80 && got < 10; c++) begin
                @(negedge clk);
                drive(0, pend, pd, pi, 0, c[0]);
                #1;
                chk($sformatf("wrap%0d issue_ok", c), {31'b0, fpu_issue_ok},
                    {31'b0, ((model_d.size() + int'(pend)) < 4)});
                chk($sformatf("wrap%0d cdb_valid", c), {31'b0, cdb_valid},
                    {31'b0, (model_d.size() != 0)});
                if (model_d.size() != 0) begin
                    chk($sformatf("wrap%0d cdb_data", c), cdb_data, model_d[0]);
                    chk($sformatf("wrap%0d cdb_idx", c), {29'b0, cdb_rob_idx}, {29'b0, model_i[0]});
                end
                fpu_start = fpu_issue_ok && (issued < 10);
                if (model_d.size() != 0 && cdb_ready) begin
                    void'(model_d.pop_front());
                    void'(model_i.pop_front());
                    got++;
                end
                if (pend) begin
                    model_d.push_back(pd);
                    model_i.push_back(pi);
                end
                pend = fpu_start;
                if (fpu_start) begin
                    pd = 32'h3F80_0000 + issued;
                    pi = 3'(issued);
                    issued++;
                end
            end
            chk("wrap received", got, 32'd10);
            chk("wrap overflow", {31'b0, overflow_err}, 32'd0);
        end

        // overflow: fill to 4 with the CDB stalled, then force a fifth result
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(0, 1, 32'hC0 + k, 3'(k), 0, 0);
            #1;
            chk($sformatf("fill%0d overflow", k), {31'b0, overflow_err}, 32'd0);
        end
        @(negedge clk);
        drive(0, 1, 32'hFFFF, 7, 0, 0);
        #1;
        chk("full issue_ok", {31'b0, fpu_issue_ok}, 32'd0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 0);
        #1;
        chk("overflow set", {31'b0, overflow_err}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(0, 0, 32'h0, 0, 0, 1);
            #1;
            chk($sformatf("ovdrain%0d data", k), cdb_data, 32'hC0 + k);
            chk($sformatf("ovdrain%0d idx", k), {29'b0, cdb_rob_idx}, k);
            chk($sformatf("ovdrain%0d sticky", k), {31'b0, overflow_err}, 32'd1);
        end
        @(negedge clk);
        #1;
        chk("ovdrain empty", {31'b0, cdb_valid}, 32'd0);
        chk("overflow still set", {31'b0, overflow_err}, 32'd1);

        // asynchronous reset mid-operation
        @(negedge clk);
        drive(0, 1, 32'hD0, 4, 0, 0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 0);
        #1;
        chk("midrst queued", {31'b0, cdb_valid}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst cdb_valid", {31'b0, cdb_valid}, 32'd0);
        chk("midrst issue_ok", {31'b0, fpu_issue_ok}, 32'd0);
        chk("midrst overflow", {31'b0, overflow_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_wb_queue.md
# fpu_wb_queue

Result buffer directly downstream of the two-stage FP add/sub unit. Captures every `fpu_o_valid` result (data + ROB index), holds it in a small FIFO, and drains it onto the common data bus (CDB) with a valid/ready handshake. The FPU itself cannot stall, so this block also issues a credit signal (`fpu_issue_ok`) that the issue stage uses to gate `fpu_start`. It also handles pipeline flush by discarding queued and in-flight FPU results.

## Interface
- `DEPTH`, 4, number of FIFO entries; power of two, ≥2
- `ROB_IDX_W`, 3, ROB index width
- `XLEN`, 32, result width
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `fpu_start`  in  1  issue stage starts an FPU op this cycle (same signal the FPU sees)
- `fpu_o_valid`  in  1  FPU result valid this cycle
- `fpu_out`  in  XLEN  FPU result
- `fpu_rob_idx`  in  ROB_IDX_W  ROB index of FPU result
- `flush`  in  1  pipeline flush; discard all FPU work
- `fpu_issue_ok`  out  1  issue stage may assert `fpu_start` this cycle
- `cdb_valid`  out  1  head entry presented on CDB
- `cdb_data`  out  XLEN  head result
- `cdb_rob_idx`  out  ROB_IDX_W  head ROB index
- `cdb_ready`  in  1  CDB accepts head this cycle
- `overflow_err`  out  1  sticky; a result arrived with no room and was lost

## Operation
- State: entry array, `rd_ptr`/`wr_ptr` (log2 DEPTH bits, wrap mod DEPTH), `occ` (0..DEPTH), `armed`, `drop_next`, `overflow_err`.
- `armed`: reset to 0, set to 1 on the first clock edge after `rst` deasserts. While `armed`=0, `fpu_o_valid` is ignored, because the FPU's valid register has no reset.
- Push condition: `push = armed & fpu_o_valid & ~flush & ~drop_next`.
- Pop condition: `pop = cdb_valid & cdb_ready & ~flush`.
- Push is accepted if `occ < DEPTH` or `pop` is high in the same cycle. A push that is not accepted drops the result and sets `overflow_err`, which is cleared only by reset.
- Simultaneous push and pop:
  - `occ` is unchanged and both pointers advance.
  - When `occ`=0, push and pop cannot coincide, because `cdb_valid`=0.
- `cdb_valid = (occ != 0)`. `cdb_data` and `cdb_rob_idx` show the entry at `rd_ptr`. They stay stable while `cdb_valid & ~cdb_ready`.
- There is no bypass. A result appears on the CDB no earlier than the cycle after its `fpu_o_valid`.
- Credit: `fpu_issue_ok = armed & ~flush & ((occ + fpu_o_valid) < DEPTH)`.
  - The term is conservative: it ignores a same-cycle pop.
  - Because the FPU holds at most one op in flight (start at t, result at t+1), honouring this credit guarantees no overflow.
- Flush in cycle t:
  - Next edge: `occ`←0 and `rd_ptr`←`wr_ptr`←0.
  - The `fpu_o_valid` seen in cycle t is dropped.
  - `drop_next`←1, so the result of any `fpu_start` sampled in cycle t (arriving at t+1) is also dropped.
  - `drop_next` is cleared on the following edge unless `flush` is still high.
  - Pop is suppressed in cycle t.
- Arithmetic: `occ` width is clog2(DEPTH+1). The credit compare uses `occ` zero-extended by 1 bit.

## Timing
- Reset values:
  - `cdb_valid`=0; `cdb_data`=0 and `cdb_rob_idx`=0 (entry array reset to 0).
  - `fpu_issue_ok`=0 (`armed`=0).
  - `overflow_err`=0, `drop_next`=0, `occ`=0, pointers 0.
- `fpu_issue_ok` rises in the first cycle after the first post-reset edge.
- Latency: `fpu_start` at t → `fpu_o_valid` at t+1 → `cdb_valid` at t+2 if the queue was empty.
- Throughput: one push and one pop per cycle.
- Reset asserted mid-operation clears everything immediately (asynchronous). In-flight results arriving during the `armed`=0 cycle are lost, by design.
- `fpu_issue_ok` and `cdb_valid` depend on `flush` and `fpu_o_valid` only through simple gates, with no path from `cdb_ready`.

## Test plan
- Reset/arming: hold `rst`=0 with `fpu_o_valid`=1 and X data, then release. Required: `cdb_valid` stays 0, `fpu_issue_ok`=0 for exactly one cycle, then 1.
- Single op: `fpu_start` at t; at t+1 `fpu_out`=0x40400000, `fpu_rob_idx`=5; `cdb_ready`=1. Required: t+2 `cdb_valid`=1, data 0x40400000, idx 5; t+3 `cdb_valid`=0.
- Backpressure/full (DEPTH=4): `cdb_ready`=0, push results idx 0,1,2,3. Required:
  - `fpu_issue_ok` goes 0 once `occ`+`fpu_o_valid` reaches 4.
  - Head is stable at idx 0.
  - Releasing `cdb_ready` drains 0,1,2,3 in order over 4 cycles.
- Concurrent push/pop with wrap: stream 10 results with `cdb_ready` toggling 1/0. Required: in-order CDB output, no loss, pointers wrap past 3→0, `occ` never exceeds 4.
- Flush:
  - Setup: 2 queued entries; `flush` at t with `fpu_o_valid`=1 and `fpu_start`=1.
  - Required: at t+1 `cdb_valid`=0 and `occ`=0; the result arriving at t+1 is dropped; the result arriving at t+2 from a start at t+1 is accepted.
- Overflow: force `fpu_o_valid` with `occ`=4 and `cdb_ready`=0. Required: the result is dropped, `overflow_err`=1 and stays 1, existing 4 entries are unchanged.
